hazard_unit: RTL

Pipeline hazard unit for the 5-stage RISC-V core with the 4-cycle multiplier. It consumes the decoded control signals carried in the ID and ID/EX stages (mem_read, reg_write, branch/jump outcome, multiply flag) and drives the stall, bubble and flush enables of the PC and pipeline registers. It covers three hazard sources: load-use, the multi-cycle MULT occupying EX, and control redirects resolved in EX. It also keeps a saturating count of stall cycles for performance debug.

---
 rtl/hazard_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use, multi-cycle MULT and EX-redirect hazard control
module hazard_unit #(
  parameter int MULT_LAT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             id_ex_mult,
  input  logic             ex_redirect,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             if_id_flush,
  output logic             mult_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    LAST = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       mult_stall;
  logic       load_use;
  logic       rs1_hit;
  logic       rs2_hit;

  // LAST never stalls, so the MULT still parked in ID/EX is not picked up twice
  assign mult_stall = (state == BUSY) || ((state == IDLE) && id_ex_mult);

  assign rs1_hit  = id_uses_rs1 && (id_rs1 == id_ex_rd);
  assign rs2_hit  = id_uses_rs2 && (id_rs2 == id_ex_rd);
  assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) && (rs1_hit || rs2_hit);

  assign mult_busy = (state != IDLE);

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    if_id_flush   = 1'b0;
    if (ex_redirect) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (mult_stall) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_bubble = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      stall_cycles <= '0;
    end else begin
      if (!pc_write && !(&stall_cycles))
        stall_cycles <= stall_cycles + CNT_W'(1);

      if (ex_redirect) begin
        state <= IDLE;
        cnt   <= 4'd0;
      end else begin
        case (state)
          IDLE: begin
            if (id_ex_mult) begin
              state <= BUSY;
              cnt   <= 4'(MULT_LAT - 2);
            end
          end
          BUSY: begin
            if (cnt == 4'd1) begin
              state <= LAST;
              cnt   <= 4'd0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          LAST: state <= IDLE;
          default: begin
            state <= IDLE;
            cnt   <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule
